usb3_rx_descram_gen: RTL and testbench

// Parametrised USB 3.0 RX symbol conditioner between the PIPE RX interface and the

---
 rtl/usb3_rx_descram_gen_if.sv | 17 +
 rtl/usb3_rx_descram_gen.sv | 193 +++++++++++++++++++
 tb/tb_usb3_rx_descram_gen.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb3_rx_descram_gen_if.sv
// Symbol-word bus between PIPE RX, the conditioner and the link-layer framer.
//   valid : word carries symbols this cycle
//   datak : K flag per symbol lane (lane 0 earliest)
//   data  : 8 bits per symbol lane (lane 0 in bits [7:0])
// master drives the word, slave receives it.
interface usb3_rx_descram_gen_if #(
  parameter int unsigned SYMS = 4
) ();

  logic              valid;
  logic [SYMS-1:0]   datak;
  logic [8*SYMS-1:0] data;

  modport master (output valid, output datak, output data);
  modport slave  (input  valid, input  datak, input  data);

endinterface

// File: rtl/usb3_rx_descram_gen.sv
// USB 3.0 RX symbol conditioner: removes SKP symbols, repacks survivors into full
// SYMS-wide words and descrambles data symbols with a per-symbol LFSR reseeded on COM.
//   local_clk : symbol-word clock
//   reset_n   : asynchronous active-low reset
//   enable    : 1 = descramble data symbols, 0 = pass through with LFSR held
//   cnt_clr   : synchronous clear of skp_cnt/com_cnt (wins over increment)
//   in_bus    : raw PIPE RX word (slave)
//   out_bus   : aligned, descrambled word (master); data/datak are 0 when not valid
//   skp_cnt   : saturating count of SKP symbols removed
//   com_cnt   : saturating count of COM symbols passed to the output
module usb3_rx_descram_gen #(
  parameter int unsigned SYMS      = 4,
  parameter logic [7:0]  SKP_SYM   = 8'h3C,
  parameter logic [7:0]  COM_SYM   = 8'hBC,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  local_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cnt_clr,
  usb3_rx_descram_gen_if.slave  in_bus,
  usb3_rx_descram_gen_if.master out_bus,
  output logic [CNT_W-1:0]      skp_cnt,
  output logic [CNT_W-1:0]      com_cnt
);

  localparam int unsigned W   = 8 * SYMS;
  localparam int unsigned FD  = 2 * SYMS - 1;
  localparam int unsigned DW  = $clog2(2 * SYMS);
  localparam int unsigned CW1 = CNT_W + 1;

  // One shift of the Galois LFSR G(x) = x^16 + x^5 + x^4 + x^3 + 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
  endfunction

  // Scramble byte: bit b is the LFSR msb after b shifts.
  function automatic logic [7:0] lfsr_key(input logic [15:0] l);
    logic [15:0] t;
    logic [7:0]  k;
    t = l;
    k = '0;
    for (int b = 0; b < 8; b++) begin
      k[b] = t[15];
      t    = lfsr_step(t);
    end
    return k;
  endfunction

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
    logic [15:0] t;
    t = l;
    for (int b = 0; b < 8; b++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [DW-1:0]    b);
    logic [CW1-1:0] s;
    s = {1'b0, a} + CW1'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [W-1:0]    s1_data;
  logic [SYMS-1:0] s1_datak;
  logic [DW-1:0]   s1_n;
  logic [8*FD-1:0] fifo_data;
  logic [FD-1:0]   fifo_k;
  logic [DW-1:0]   depth;
  logic [15:0]     lfsr_q;

  logic [W-1:0]    c1_data;
  logic [SYMS-1:0] c1_datak;
  logic [DW-1:0]   c1_n;
  logic [DW-1:0]   c1_skp;

  // Stage 1: drop SKP lanes anywhere in the word and pack survivors toward lane 0.
  always_comb begin
    int unsigned k;
    int unsigned s;
    k        = 0;
    s        = 0;
    c1_data  = '0;
    c1_datak = '0;
    for (int unsigned i = 0; i < SYMS; i++) begin
      if (in_bus.valid) begin
        if (in_bus.datak[i] && (in_bus.data[8*i +: 8] == SKP_SYM)) begin
          s = s + 1;
        end else begin
          c1_data[8*k +: 8] = in_bus.data[8*i +: 8];
          c1_datak[k]       = in_bus.datak[i];
          k = k + 1;
        end
      end
    end
    c1_n   = DW'(k);
    c1_skp = DW'(s);
  end

  logic            pop;
  logic [8*FD-1:0] nxt_data;
  logic [FD-1:0]   nxt_k;
  logic [DW-1:0]   nxt_depth;

  // Stage 2: pop a full word if one was already held, then append this cycle's symbols.
  always_comb begin
    int unsigned base;
    int unsigned n;
    pop      = (depth >= DW'(SYMS));
    nxt_data = pop ? (fifo_data >> W) : fifo_data;
    nxt_k    = pop ? (fifo_k >> SYMS) : fifo_k;
    base     = 32'(depth);
    if (pop) base = base - SYMS;
    n        = 32'(s1_n);
    for (int unsigned i = 0; i < SYMS; i++) begin
      if ((i < n) && ((base + i) < FD)) begin
        nxt_data[8*(base+i) +: 8] = s1_data[8*i +: 8];
        nxt_k[base+i]             = s1_datak[i];
      end
    end
    nxt_depth = DW'(base + n);
  end

  logic [W-1:0]    c3_data;
  logic [SYMS-1:0] c3_datak;
  logic [15:0]     c3_lfsr;
  logic [DW-1:0]   c3_com;

  // Stage 3: descramble the popped word lane by lane; a COM reseeds for the lanes after it.
  always_comb begin
    logic [15:0] l;
    logic [7:0]  d;
    int unsigned coms;
    l        = lfsr_q;
    d        = '0;
    coms     = 0;
    c3_data  = '0;
    c3_datak = fifo_k[SYMS-1:0];
    for (int unsigned i = 0; i < SYMS; i++) begin
      d = fifo_data[8*i +: 8];
      if (fifo_k[i] && (d == COM_SYM)) begin
        c3_data[8*i +: 8] = d;
        l    = LFSR_SEED;
        coms = coms + 1;
      end else if (fifo_k[i]) begin
        c3_data[8*i +: 8] = d;
        if (enable) l = lfsr_adv8(l);
      end else if (enable) begin
        c3_data[8*i +: 8] = d ^ lfsr_key(l);
        l = lfsr_adv8(l);
      end else begin
        c3_data[8*i +: 8] = d;
      end
    end
    c3_lfsr = l;
    c3_com  = DW'(coms);
  end

  // Pipeline, accumulator, LFSR and statistics registers.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data       <= '0;
      s1_datak      <= '0;
      s1_n          <= '0;
      fifo_data     <= '0;
      fifo_k        <= '0;
      depth         <= '0;
      lfsr_q        <= LFSR_SEED;
      out_bus.valid <= 1'b0;
      out_bus.data  <= '0;
      out_bus.datak <= '0;
      skp_cnt       <= '0;
      com_cnt       <= '0;
    end else begin
      s1_data       <= c1_data;
      s1_datak      <= c1_datak;
      s1_n          <= c1_n;
      fifo_data     <= nxt_data;
      fifo_k        <= nxt_k;
      depth         <= nxt_depth;
      out_bus.valid <= pop;
      out_bus.data  <= pop ? c3_data  : '0;
      out_bus.datak <= pop ? c3_datak : '0;
      if (pop) lfsr_q <= c3_lfsr;
      if (cnt_clr) skp_cnt <= '0;
      else         skp_cnt <= sat_add(skp_cnt, c1_skp);
      if (cnt_clr)  com_cnt <= '0;
      else if (pop) com_cnt <= sat_add(com_cnt, c3_com);
    end
  end

endmodule

// File: tb/tb_usb3_rx_descram_gen.sv
module tb_usb3_rx_descram_gen;

  typedef struct packed { logic k; logic [7:0] d; } sym_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; } wrd_t;

  logic        local_clk = 1'b0;
  logic        rst4_n, rst2_n, en4, en2, clr4, clr2;
  logic [15:0] skp4, com4, skp2, com2;

  usb3_rx_descram_gen_if #(.SYMS(4)) in4 ();
  usb3_rx_descram_gen_if #(.SYMS(4)) out4 ();
  usb3_rx_descram_gen_if #(.SYMS(2)) in2 ();
  usb3_rx_descram_gen_if #(.SYMS(2)) out2 ();

  usb3_rx_descram_gen #(.SYMS(4)) u4 (
    .local_clk(local_clk), .reset_n(rst4_n), .enable(en4), .cnt_clr(clr4),
    .in_bus(in4), .out_bus(out4), .skp_cnt(skp4), .com_cnt(com4));

  usb3_rx_descram_gen #(.SYMS(2)) u2 (
    .local_clk(local_clk), .reset_n(rst2_n), .enable(en2), .cnt_clr(clr2),
    .in_bus(in2), .out_bus(out2), .skp_cnt(skp2), .com_cnt(com2));

  always #5 local_clk = ~local_clk;

  int unsigned cyc = 0;
  always @(posedge local_clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state; index 0 = SYMS 4 instance, 1 = SYMS 2 instance.
  logic [7:0]  ks [0:8191];
  sym_t        symq  [2][$];
  wrd_t        exp_q [2][$];
  wrd_t        got_q [2][$];
  int unsigned got_t [2][$];
  int unsigned in_t  [2][$];
  int          p [2];
  int          skp_exp [2];
  int          com_exp [2];

  always @(negedge local_clk) begin
    if (out4.valid === 1'b1) begin
      got_q[0].push_back({out4.data, out4.datak});
      got_t[0].push_back(cyc);
    end
    if (out2.valid === 1'b1) begin
      got_q[1].push_back({16'h0, out2.data, 2'b00, out2.datak});
      got_t[1].push_back(cyc);
    end
  end

  // Keystream bytes produced from the seed, bit 0 first.
  task automatic build_keystream();
    logic [15:0] l;
    l = 16'hFFFF;
    for (int b = 0; b < 8192 * 8; b++) begin
      ks[b / 8][b % 8] = l[15];
      l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
  endtask

  // Symbol-stream model: strip SKPs, chunk into words, descramble by keystream position.
  task automatic model_push(input int u, input int syms, input logic en,
                            input logic [31:0] d, input logic [3:0] k);
    sym_t s;
    wrd_t w;
    for (int i = 0; i < syms; i++) begin
      s.k = k[i];
      s.d = d[8*i +: 8];
      if (s.k && s.d == 8'h3C) begin
        if (skp_exp[u] < 65535) skp_exp[u]++;
      end else symq[u].push_back(s);
    end
    while (symq[u].size() >= syms) begin
      w = '0;
      for (int j = 0; j < syms; j++) begin
        s = symq[u].pop_front();
        w.k[j] = s.k;
        w.d[8*j +: 8] = s.d;
        if (s.k && s.d == 8'hBC) begin
          p[u] = 0;
          if (com_exp[u] < 65535) com_exp[u]++;
        end else if (en) begin
          if (!s.k) w.d[8*j +: 8] = s.d ^ ks[p[u]];
          p[u]++;
        end
      end
      exp_q[u].push_back(w);
    end
  endtask

  task automatic drive(input int u, input logic [31:0] d, input logic [3:0] k);
    @(negedge local_clk);
    if (u == 0) begin
      in4.valid = 1'b1; in4.data = d; in4.datak = k;
      model_push(0, 4, en4, d, k);
    end else begin
      in2.valid = 1'b1; in2.data = d[15:0]; in2.datak = k[1:0];
      model_push(1, 2, en2, d, k);
    end
    in_t[u].push_back(cyc);
  endtask

  // Invalid cycles carry SKP-looking symbols that must not be counted.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge local_clk);
      in4.valid = 1'b0; in4.data = 32'h3C3C3C3C; in4.datak = 4'hF;
      in2.valid = 1'b0; in2.data = 16'h3C3C;     in2.datak = 2'h3;
    end
  endtask

  task automatic clear_obs(input int u);
    got_q[u].delete(); got_t[u].delete(); exp_q[u].delete(); in_t[u].delete();
  endtask

  task automatic test_reset();
    rst4_n = 1'b0; rst2_n = 1'b0; en4 = 1'b1; en2 = 1'b1; clr4 = 1'b0; clr2 = 1'b0;
    idle(3);
    #1;
    tests_run++;
    if (out4.valid !== 1'b0 || out4.data !== 32'h0 || out4.datak !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_out4 got v=%b d=%h k=%h exp v=0 d=0 k=0", out4.valid, out4.data, out4.datak);
    end
    tests_run++;
    if (skp4 !== 16'h0 || com4 !== 16'h0) begin
      tests_failed++; $display("FAIL reset_cnt4 got skp=%h com=%h exp 0 0", skp4, com4);
    end
    tests_run++;
    if (out2.valid !== 1'b0 || out2.data !== 16'h0 || skp2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_out2 got v=%b d=%h skp=%h exp 0 0 0", out2.valid, out2.data, skp2);
    end
    rst4_n = 1'b1; rst2_n = 1'b1;
    idle(4);
    tests_run++;
    if (out4.valid !== 1'b0 || skp4 !== 16'h0) begin
      tests_failed++; $display("FAIL idle_invalid got v=%b skp=%h exp 0 0", out4.valid, skp4);
    end
  endtask

  task automatic test_com_keystream();
    clear_obs(0);
    en4 = 1'b1;
    drive(0, 32'h000000BC, 4'b0001);
    repeat (4) drive(0, 32'h0, 4'h0);
    idle(6);
    tests_run++;
    if (got_q[0].size() !== 5) begin
      tests_failed++; $display("FAIL com_count got %0d exp 5", got_q[0].size());
    end
    for (int i = 0; i < got_q[0].size() && i < exp_q[0].size(); i++) begin
      tests_run++;
      if (got_q[0][i] !== exp_q[0][i]) begin
        tests_failed++; $display("FAIL com_word%0d got %h exp %h", i, got_q[0][i], exp_q[0][i]);
      end
      tests_run++;
      if (got_t[0][i] - in_t[0][i] !== 3) begin
        tests_failed++; $display("FAIL com_latency%0d got %0d exp 3", i, got_t[0][i] - in_t[0][i]);
      end
    end
    if (got_q[0].size() > 0) begin
      tests_run++;
      if (got_q[0][0] !== {32'hC017FFBC, 4'b0001}) begin
        tests_failed++; $display("FAIL com_first got %h exp %h", got_q[0][0], {32'hC017FFBC, 4'b0001});
      end
    end
    tests_run++;
    if (com4 !== 16'(com_exp[0])) begin
      tests_failed++; $display("FAIL com_cnt got %0d exp %0d", com4, com_exp[0]);
    end
  endtask

  task automatic test_skp_noncontig();
    logic [7:0] dv [0:7];
    clear_obs(0);
    en4 = 1'b0;
    for (int i = 0; i < 8; i++) dv[i] = 8'($urandom);
    drive(0, {8'h3C, dv[1], 8'h3C, dv[0]}, 4'b1010);
    drive(0, {dv[5], dv[4], dv[3], dv[2]}, 4'b0000);
    idle(6);
    tests_run++;
    if (got_q[0].size() !== 1) begin
      tests_failed++; $display("FAIL nc_count got %0d exp 1", got_q[0].size());
    end else begin
      tests_run++;
      if (got_q[0][0] !== {dv[3], dv[2], dv[1], dv[0], 4'h0}) begin
        tests_failed++; $display("FAIL nc_word0 got %h exp %h", got_q[0][0], {dv[3], dv[2], dv[1], dv[0], 4'h0});
      end
    end
    tests_run++;
    if (skp4 !== 16'(skp_exp[0])) begin
      tests_failed++; $display("FAIL nc_skp got %0d exp %0d", skp4, skp_exp[0]);
    end
    drive(0, {8'h3C, 8'h3C, dv[7], dv[6]}, 4'b1100);
    idle(6);
    tests_run++;
    if (got_q[0].size() !== 2) begin
      tests_failed++; $display("FAIL nc_count2 got %0d exp 2", got_q[0].size());
    end else begin
      tests_run++;
      if (got_q[0][1] !== {dv[7], dv[6], dv[5], dv[4], 4'h0}) begin
        tests_failed++; $display("FAIL nc_word1 got %h exp %h", got_q[0][1], {dv[7], dv[6], dv[5], dv[4], 4'h0});
      end
    end
  endtask

  task automatic test_all_skp();
    clear_obs(0);
    en4 = 1'b1;
    drive(0, $urandom, 4'h0);
    drive(0, 32'h3C3C3C3C, 4'hF);
    drive(0, $urandom, 4'h0);
    idle(6);
    tests_run++;
    if (got_q[0].size() !== 2) begin
      tests_failed++; $display("FAIL allskp_count got %0d exp 2", got_q[0].size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (got_q[0][i] !== exp_q[0][i]) begin
          tests_failed++; $display("FAIL allskp_word%0d got %h exp %h", i, got_q[0][i], exp_q[0][i]);
        end
      end
      tests_run++;
      if (got_t[0][1] - got_t[0][0] !== 2) begin
        tests_failed++; $display("FAIL allskp_gap got %0d exp 2", got_t[0][1] - got_t[0][0]);
      end
    end
    tests_run++;
    if (skp4 !== 16'(skp_exp[0])) begin
      tests_failed++; $display("FAIL allskp_skp got %0d exp %0d", skp4, skp_exp[0]);
    end
    tests_run++;
    if (out4.data !== 32'h0 || out4.datak !== 4'h0) begin
      tests_failed++; $display("FAIL idle_zero got d=%h k=%h exp 0 0", out4.data, out4.datak);
    end
  endtask

  task automatic test_bypass();
    clear_obs(0);
    en4 = 1'b0;
    repeat (3) drive(0, 32'h12345678, 4'h0);
    drive(0, 32'h123456BC, 4'b0001);
    idle(6);
    en4 = 1'b1;
    drive(0, 32'h0, 4'h0);
    idle(6);
    tests_run++;
    if (got_q[0].size() !== 5) begin
      tests_failed++; $display("FAIL byp_count got %0d exp 5", got_q[0].size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_q[0][i] !== {32'h12345678, 4'h0}) begin
          tests_failed++; $display("FAIL byp_word%0d got %h exp %h", i, got_q[0][i], {32'h12345678, 4'h0});
        end
      end
      tests_run++;
      if (got_q[0][3] !== {32'h123456BC, 4'b0001}) begin
        tests_failed++; $display("FAIL byp_com got %h exp %h", got_q[0][3], {32'h123456BC, 4'b0001});
      end
      tests_run++;
      if (got_q[0][4] !== {32'h14C017FF, 4'h0}) begin
        tests_failed++; $display("FAIL byp_restart got %h exp %h", got_q[0][4], {32'h14C017FF, 4'h0});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [3:0]  k;
    int          r;
    clear_obs(0);
    en4 = 1'b1;
    for (int w = 0; w < 40; w++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0, 1:    begin k[i] = 1'b1; d[8*i +: 8] = 8'h3C; end
          2:       begin k[i] = 1'b1; d[8*i +: 8] = 8'hBC; end
          3:       begin k[i] = 1'b1; d[8*i +: 8] = 8'hF7; end
          default: begin k[i] = 1'b0; d[8*i +: 8] = 8'($urandom); end
        endcase
      end
      drive(0, d, k);
    end
    r = symq[0].size();
    if (r != 0) begin
      d = $urandom;
      k = 4'h0;
      for (int i = 4 - r; i < 4; i++) begin
        k[i] = 1'b1; d[8*i +: 8] = 8'h3C;
      end
      drive(0, d, k);
    end
    idle(6);
    tests_run++;
    if (got_q[0].size() !== exp_q[0].size()) begin
      tests_failed++; $display("FAIL rnd_count got %0d exp %0d", got_q[0].size(), exp_q[0].size());
    end
    for (int i = 0; i < got_q[0].size() && i < exp_q[0].size(); i++) begin
      tests_run++;
      if (got_q[0][i] !== exp_q[0][i]) begin
        tests_failed++; $display("FAIL rnd_word%0d got %h exp %h", i, got_q[0][i], exp_q[0][i]);
      end
    end
    tests_run++;
    if (skp4 !== 16'(skp_exp[0]) || com4 !== 16'(com_exp[0])) begin
      tests_failed++;
      $display("FAIL rnd_cnt got skp=%0d com=%0d exp %0d %0d", skp4, com4, skp_exp[0], com_exp[0]);
    end
  endtask

  task automatic test_skp_saturate();
    clear_obs(0);
    while (skp_exp[0] < 65535) drive(0, 32'h3C3C3C3C, 4'hF);
    idle(3);
    tests_run++;
    if (skp4 !== 16'hFFFF) begin
      tests_failed++; $display("FAIL sat_full got %h exp ffff", skp4);
    end
    drive(0, 32'h3C3C3C3C, 4'hF);
    idle(3);
    tests_run++;
    if (skp4 !== 16'hFFFF) begin
      tests_failed++; $display("FAIL sat_hold got %h exp ffff", skp4);
    end
    drive(0, 32'h3C3C3C3C, 4'hF);
    clr4 = 1'b1;
    skp_exp[0] = 0;
    com_exp[0] = 0;
    idle(1);
    clr4 = 1'b0;
    idle(3);
    tests_run++;
    if (skp4 !== 16'h0 || com4 !== 16'h0) begin
      tests_failed++; $display("FAIL sat_clr got skp=%h com=%h exp 0 0", skp4, com4);
    end
  endtask

  task automatic test_syms2_reset();
    logic [15:0] wn;
    clear_obs(1);
    en2 = 1'b1;
    drive(1, 32'($urandom_range(0, 65535)), 4'h0);
    drive(1, {16'h0, 8'h3C, 8'($urandom)}, 4'b0010);
    idle(2);
    #1;
    tests_run++;
    if (got_q[1].size() !== 1) begin
      tests_failed++; $display("FAIL s2_pre_count got %0d exp 1", got_q[1].size());
    end else begin
      tests_run++;
      if (got_q[1][0] !== exp_q[1][0]) begin
        tests_failed++; $display("FAIL s2_pre_word got %h exp %h", got_q[1][0], exp_q[1][0]);
      end
    end
    rst2_n = 1'b0;
    #1;
    tests_run++;
    if (out2.valid !== 1'b0 || out2.data !== 16'h0 || skp2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL s2_rst got v=%b d=%h skp=%h exp 0 0 0", out2.valid, out2.data, skp2);
    end
    symq[1].delete(); p[1] = 0; skp_exp[1] = 0; com_exp[1] = 0;
    clear_obs(1);
    #1 rst2_n = 1'b1;
    wn = 16'($urandom);
    drive(1, {16'h0, wn}, 4'h0);
    idle(8);
    tests_run++;
    if (got_q[1].size() !== 1) begin
      tests_failed++; $display("FAIL s2_post_count got %0d exp 1", got_q[1].size());
    end else begin
      tests_run++;
      if (got_q[1][0] !== {16'h0, wn ^ 16'h17FF, 4'h0}) begin
        tests_failed++; $display("FAIL s2_post_word got %h exp %h", got_q[1][0], {16'h0, wn ^ 16'h17FF, 4'h0});
      end
      tests_run++;
      if (got_t[1][0] - in_t[1][0] !== 3) begin
        tests_failed++; $display("FAIL s2_latency got %0d exp 3", got_t[1][0] - in_t[1][0]);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      p[u] = 0; skp_exp[u] = 0; com_exp[u] = 0;
    end
    build_keystream();
    test_reset();
    test_com_keystream();
    test_skp_noncontig();
    test_all_skp();
    test_bypass();
    test_random();
    test_syms2_reset();
    test_skp_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
